// File: rtl/hpdmc_wrpath_pkg.sv
// Shared definitions for the DDR write-data sequencer: FSM encoding, counter width
// and the DQS levels driven in each phase.
package hpdmc_wrpath_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_PRE   = 3'd2,
    ST_BURST = 3'd3,
    ST_POST  = 3'd4
  } wr_state_e;

  localparam int CNT_W = 4;

  // Per-lane DQS levels. Preamble/postamble drive the strobe low on both edges.
  localparam logic DQS_BURST_D0 = 1'b1;
  localparam logic DQS_BURST_D1 = 1'b0;
  localparam logic DQS_QUIET    = 1'b0;

endpackage

// File: rtl/hpdmc_wrpath_if.sv
// Scheduler/buffer side and DDR-register side of the write-data sequencer.
interface hpdmc_wrpath_if #(
  parameter int DQ_WIDTH = 16
);
  localparam int NB = DQ_WIDTH / 8;

  logic                  write;
  logic [2*DQ_WIDTH-1:0] wdata;
  logic [2*NB-1:0]       wmask;
  logic                  wdata_valid;
  logic                  wdata_ack;
  logic                  err_clr;

  logic [DQ_WIDTH-1:0]   dq_d0;
  logic [DQ_WIDTH-1:0]   dq_d1;
  logic [NB-1:0]         dm_d0;
  logic [NB-1:0]         dm_d1;
  logic [NB-1:0]         dqs_d0;
  logic [NB-1:0]         dqs_d1;
  logic                  dq_oe;
  logic                  dqs_oe;
  logic                  busy;
  logic                  underrun;
  logic                  collision;

  modport slave (
    input  write, wdata, wmask, wdata_valid, err_clr,
    output wdata_ack, dq_d0, dq_d1, dm_d0, dm_d1, dqs_d0, dqs_d1,
           dq_oe, dqs_oe, busy, underrun, collision
  );

  modport master (
    output write, wdata, wmask, wdata_valid, err_clr,
    input  wdata_ack, dq_d0, dq_d1, dm_d0, dm_d1, dqs_d0, dqs_d1,
           dq_oe, dqs_oe, busy, underrun, collision
  );

endinterface

// File: rtl/hpdmc_wrpath.sv
// Write-data sequencer: after a WRITE strobe waits the write latency, then drives
// DQS preamble, the data burst and postamble into the output DDR registers.
module hpdmc_wrpath
  import hpdmc_wrpath_pkg::*;
#(
  parameter int DQ_WIDTH     = 16,
  parameter int BURST_CYCLES = 4,
  parameter int WL_CYCLES    = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  hpdmc_wrpath_if.slave       wp
);

  localparam int NB = DQ_WIDTH / 8;
  localparam logic [CNT_W-1:0] WL_LOAD    = (WL_CYCLES > 0) ? CNT_W'(WL_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(BURST_CYCLES - 1);

  wr_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DQ_WIDTH-1:0] dq_d0_q, dq_d0_d, dq_d1_q, dq_d1_d;
  logic [NB-1:0]       dm_d0_q, dm_d0_d, dm_d1_q, dm_d1_d;
  logic [NB-1:0]       dqs_d0_q, dqs_d0_d, dqs_d1_q, dqs_d1_d;
  logic                dq_oe_q, dq_oe_d, dqs_oe_q, dqs_oe_d;
  logic                busy_q, busy_d;
  logic                underrun_q, underrun_d, collision_q, collision_d;
  logic                ack;

  // Ack depends only on state/counter so the upstream buffer may gate valid on it.
  assign ack = (state_q == ST_PRE) || ((state_q == ST_BURST) && (cnt_q != '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wp.write) begin
          if (WL_CYCLES == 0) begin
            state_d = ST_PRE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WL_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_PRE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_PRE: begin
        state_d = ST_BURST;
        cnt_d   = BURST_LOAD;
      end
      ST_BURST: begin
        if (cnt_q == '0) state_d = ST_POST;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_POST:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    dq_oe_d  = (state_d == ST_BURST);
    dqs_oe_d = (state_d == ST_PRE) || (state_d == ST_BURST) || (state_d == ST_POST);
    dqs_d0_d = {NB{dq_oe_d ? DQS_BURST_D0 : DQS_QUIET}};
    dqs_d1_d = {NB{dq_oe_d ? DQS_BURST_D1 : DQS_QUIET}};
    busy_d   = (state_d != ST_IDLE);
    dq_d0_d  = '0;
    dq_d1_d  = '0;
    dm_d0_d  = '0;
    dm_d1_d  = '0;
    // Every ack cycle is followed by a BURST cycle, so the loaded word is always shown.
    if (ack) begin
      if (wp.wdata_valid) begin
        dq_d0_d = wp.wdata[DQ_WIDTH-1:0];
        dq_d1_d = wp.wdata[2*DQ_WIDTH-1:DQ_WIDTH];
        dm_d0_d = wp.wmask[NB-1:0];
        dm_d1_d = wp.wmask[2*NB-1:NB];
      end else begin
        dm_d0_d = '1;
        dm_d1_d = '1;
      end
    end
    underrun_d  = (underrun_q  & ~wp.err_clr) | (ack & ~wp.wdata_valid);
    collision_d = (collision_q & ~wp.err_clr) | (wp.write & (state_q != ST_IDLE));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dq_d0_q     <= '0;
      dq_d1_q     <= '0;
      dm_d0_q     <= '0;
      dm_d1_q     <= '0;
      dqs_d0_q    <= '0;
      dqs_d1_q    <= '0;
      dq_oe_q     <= 1'b0;
      dqs_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dq_d0_q     <= dq_d0_d;
      dq_d1_q     <= dq_d1_d;
      dm_d0_q     <= dm_d0_d;
      dm_d1_q     <= dm_d1_d;
      dqs_d0_q    <= dqs_d0_d;
      dqs_d1_q    <= dqs_d1_d;
      dq_oe_q     <= dq_oe_d;
      dqs_oe_q    <= dqs_oe_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
      collision_q <= collision_d;
    end
  end

  assign wp.wdata_ack = ack;
  assign wp.dq_d0     = dq_d0_q;
  assign wp.dq_d1     = dq_d1_q;
  assign wp.dm_d0     = dm_d0_q;
  assign wp.dm_d1     = dm_d1_q;
  assign wp.dqs_d0    = dqs_d0_q;
  assign wp.dqs_d1    = dqs_d1_q;
  assign wp.dq_oe     = dq_oe_q;
  assign wp.dqs_oe    = dqs_oe_q;
  assign wp.busy      = busy_q;
  assign wp.underrun  = underrun_q;
  assign wp.collision = collision_q;

endmodule

// File: tb/tb_hpdmc_wrpath.sv
// Directed bench for hpdmc_wrpath: default build (WL=1, BL=4) and a WL=0, BL=1 build.
module tb_hpdmc_wrpath;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] W [4] = '{32'hA1A2_B1B2, 32'hC3C4_D3D4, 32'hE5E6_F5F6, 32'h0718_2938};
  logic [3:0]  M [4] = '{4'h0, 4'h5, 4'hA, 4'h3};

  always #5 sys_clk = ~sys_clk;

  hpdmc_wrpath_if #(.DQ_WIDTH(16)) wp ();
  hpdmc_wrpath_if #(.DQ_WIDTH(16)) wq ();

  hpdmc_wrpath #(.DQ_WIDTH(16), .BURST_CYCLES(4), .WL_CYCLES(1)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wp      (wp)
  );

  hpdmc_wrpath #(.DQ_WIDTH(16), .BURST_CYCLES(1), .WL_CYCLES(0)) dut_short (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wp      (wq)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are then changed and outputs sampled 1ns after the edge.
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  // Write in the current cycle (cycle 0); checks cycles 1..8. vmask[k]=wdata_valid for beat k.
  task automatic run_burst(input logic [3:0] vmask, input bit coll4);
    int k;
    int b;
    wp.write = 1'b1;
    wp.wdata = W[0]; wp.wmask = M[0]; wp.wdata_valid = vmask[0];
    for (int c = 1; c <= 8; c++) begin
      cyc();
      wp.write = coll4 && (c == 4);
      k = (c < 2) ? 0 : ((c > 5) ? 3 : c - 2);
      wp.wdata = W[k]; wp.wmask = M[k]; wp.wdata_valid = vmask[k];
      chk($sformatf("ack c%0d", c), wp.wdata_ack, (c >= 2 && c <= 5));
      chk($sformatf("busy/dqs_oe/dq_oe c%0d", c), {wp.busy, wp.dqs_oe, wp.dq_oe},
          {c <= 7, c >= 2 && c <= 7, c >= 3 && c <= 6});
      chk($sformatf("dqs c%0d", c), {wp.dqs_d0, wp.dqs_d1},
          (c >= 3 && c <= 6) ? 4'b1100 : 4'b0000);
      if (c >= 3 && c <= 6) begin
        b = c - 3;
        chk($sformatf("dq beat%0d", b), {wp.dq_d1, wp.dq_d0}, vmask[b] ? W[b] : 32'h0);
        chk($sformatf("dm beat%0d", b), {wp.dm_d1, wp.dm_d0}, vmask[b] ? M[b] : 4'hF);
      end else begin
        chk($sformatf("dq/dm quiet c%0d", c), {wp.dq_d1, wp.dq_d0, wp.dm_d1, wp.dm_d0}, 36'h0);
      end
    end
    wp.wdata_valid = 1'b0;
  endtask

  initial begin
    wp.write = 0; wp.wdata = '0; wp.wmask = '0; wp.wdata_valid = 0; wp.err_clr = 0;
    wq.write = 0; wq.wdata = '0; wq.wmask = '0; wq.wdata_valid = 0; wq.err_clr = 0;
    cyc(); cyc();
    chk("reset ctl", {wp.busy, wp.dq_oe, wp.dqs_oe, wp.underrun, wp.collision, wp.wdata_ack}, 6'h0);
    chk("reset data", {wp.dq_d1, wp.dq_d0, wp.dm_d1, wp.dm_d0, wp.dqs_d1, wp.dqs_d0}, 40'h0);
    sys_rst = 1'b0;
    cyc();

    // Clean burst, with wmask=0x5 on beat 1.
    run_burst(4'b1111, 1'b0);
    chk("t1 flags", {wp.underrun, wp.collision}, 2'b00);
    cyc();

    // Third beat not valid.
    run_burst(4'b1011, 1'b0);
    chk("t2 underrun set", wp.underrun, 1'b1);
    wp.err_clr = 1'b1;
    cyc();
    wp.err_clr = 1'b0;
    chk("t2 underrun clr", wp.underrun, 1'b0);
    cyc();

    // Write during BURST is dropped; the burst itself is unaffected.
    run_burst(4'b1111, 1'b1);
    chk("t3 collision", {wp.collision, wp.underrun}, 2'b10);
    cyc();
    run_burst(4'b1111, 1'b0);
    chk("t3 next write", {wp.collision, wp.underrun}, 2'b10);
    wp.err_clr = 1'b1;
    cyc();
    wp.err_clr = 1'b0;
    chk("t3 collision clr", wp.collision, 1'b0);

    // Reset during the second BURST cycle (cycle 4).
    wp.write = 1'b1; wp.wdata = W[1]; wp.wdata_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      wp.write = 1'b0;
    end
    chk("t4 in burst", {wp.dq_oe, wp.dqs_oe, wp.busy}, 3'b111);
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    wp.wdata_valid = 1'b0;
    chk("t4 reset ctl", {wp.busy, wp.dq_oe, wp.dqs_oe, wp.wdata_ack}, 4'h0);
    chk("t4 reset data", {wp.dq_d1, wp.dq_d0, wp.dm_d1, wp.dm_d0, wp.dqs_d1, wp.dqs_d0}, 40'h0);
    cyc();
    chk("t4 stays idle", {wp.busy, wp.dqs_oe}, 2'b00);
    run_burst(4'b1111, 1'b0);
    chk("t4 after flags", {wp.underrun, wp.collision}, 2'b00);

    // WL=0, BL=1 build: PRE at +1, one beat at +2, POST at +3.
    wq.write = 1'b1; wq.wdata = W[2]; wq.wmask = M[2]; wq.wdata_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      wq.write = 1'b0;
      chk($sformatf("t5 ack c%0d", c), wq.wdata_ack, (c == 1));
      chk($sformatf("t5 busy/dqs_oe/dq_oe c%0d", c), {wq.busy, wq.dqs_oe, wq.dq_oe},
          {c <= 3, c <= 3, c == 2});
      chk($sformatf("t5 dqs c%0d", c), {wq.dqs_d0, wq.dqs_d1}, (c == 2) ? 4'b1100 : 4'b0000);
      chk($sformatf("t5 dq c%0d", c), {wq.dq_d1, wq.dq_d0}, (c == 2) ? W[2] : 32'h0);
      chk($sformatf("t5 dm c%0d", c), {wq.dm_d1, wq.dm_d0}, (c == 2) ? M[2] : 4'h0);
    end
    chk("t5 flags", {wq.underrun, wq.collision}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
